// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, length and owner encodings for mem_arbiter.
// The arbitration policy (MEM_ARB_ROUND_ROBIN_EN) is resolved in mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS,
        DRAIN
    } arb_state_t;

    localparam logic [2:0] LEN_B = 3'b000;
    localparam logic [2:0] LEN_H = 3'b001;
    localparam logic [2:0] LEN_W = 3'b010;
    localparam int LEN_SIGNED_BIT = 2;

    localparam int OWN_IF = 0;
    localparam int OWN_LS = 1;
    localparam int N_REQ = 2;

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selection between IF and LS requesters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating priority; otherwise LS always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     upd,
    input  req_vec_t elig,
    input  req_vec_t mask,
    output req_vec_t grant
);

    req_vec_t cand;

    assign cand = elig & ~mask;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = LS was granted last; reset leaves LS as the favoured requester
    logic last_ls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ls <= 1'b0;
        end else if (upd) begin
            last_ls <= grant[OWN_LS];
        end
    end

    always_comb begin
        grant = '0;
        if (&cand) begin
            if (last_ls) begin
                grant[OWN_IF] = 1'b1;
            end else begin
                grant[OWN_LS] = 1'b1;
            end
        end else begin
            grant = cand;
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{clk, rst_n, upd};

    always_comb begin
        grant = '0;
        if (cand[OWN_LS]) begin
            grant[OWN_LS] = 1'b1;
        end else if (cand[OWN_IF]) begin
            grant[OWN_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory controller between IF and LS.
// Grant policy comes from mem_arb_pick (MEM_ARB_ROUND_ROBIN_EN or fixed LS-first).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_valid,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [2:0]        ls_len,
    input  logic [DATA_W-1:0] ls_data,
    output logic              ls_ready,
    output logic [DATA_W-1:0] ls_res,
    output logic              mem_valid,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_len,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_res
);

    arb_state_t state;
    arb_state_t state_nx;
    req_vec_t   elig;
    req_vec_t   mask;
    req_vec_t   grant;
    logic       open;
    logic       done;
    logic       take;

    assign elig[OWN_IF] = if_valid && !flush_in;
    assign elig[OWN_LS] = ls_valid;

    mem_arb_pick u_pick (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .upd   (take),
        .elig  (elig),
        .mask  (mask),
        .grant (grant)
    );

    // A finishing owner still holds valid in its ready cycle, so mask it
    always_comb begin
        done = 1'b0;
        mask = '0;
        unique case (state)
            IDLE: begin
                done = 1'b0;
            end
            BUSY_IF: begin
                done         = mem_ready;
                mask[OWN_IF] = 1'b1;
            end
            BUSY_LS: begin
                done         = mem_ready;
                mask[OWN_LS] = 1'b1;
            end
            DRAIN: begin
                done         = mem_ready;
                mask[OWN_IF] = 1'b1;
            end
        endcase
        open = (state == IDLE) || done;
        take = open && rdy_in && (grant != '0);
    end

    always_comb begin
        state_nx = state;
        if (take) begin
            state_nx = grant[OWN_IF] ? BUSY_IF : BUSY_LS;
        end else if (done) begin
            state_nx = IDLE;
        end else if (state == BUSY_IF && flush_in) begin
            state_nx = DRAIN;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_len   <= '0;
            mem_data  <= '0;
        end else if (rdy_in) begin
            state <= state_nx;
            if (take) begin
                mem_valid <= 1'b1;
                if (grant[OWN_IF]) begin
                    mem_wr   <= 1'b0;
                    mem_addr <= if_addr;
                    mem_len  <= LEN_W;
                    mem_data <= '0;
                end else begin
                    mem_wr   <= ls_wr;
                    mem_addr <= ls_addr;
                    mem_len  <= ls_len;
                    mem_data <= ls_data;
                end
            end else if (done) begin
                mem_valid <= 1'b0;
            end
        end
    end

    // A flush in the completion cycle swallows the IF response
    assign if_ready = (state == BUSY_IF) && mem_ready && !flush_in;
    assign ls_ready = (state == BUSY_LS) && mem_ready;
    assign if_data  = if_ready ? mem_res : '0;
    assign ls_res   = ls_ready ? mem_res : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scoreboard bench for mem_arbiter.
// A byte-addressed controller model answers requests; expectations come from a separate reference memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BUDGET = 300;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          flush_in = 1'b0;
    logic          if_valid = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_data;
    logic          ls_valid = 1'b0;
    logic          ls_wr = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [2:0]    ls_len = '0;
    logic [DW-1:0] ls_data = '0;
    logic          ls_ready;
    logic [DW-1:0] ls_res;
    logic          mem_valid;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_len;
    logic [DW-1:0] mem_data;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_res = '0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] ls_q[$];
    logic [7:0] ref_mem[logic [AW-1:0]];
    logic [7:0] ctl_mem[logic [AW-1:0]];
    int ctrl_lat = 2;
    bit rdy_rand = 1'b0;
    bit rdy_hold = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .ls_valid  (ls_valid),
        .ls_wr     (ls_wr),
        .ls_addr   (ls_addr),
        .ls_len    (ls_len),
        .ls_data   (ls_data),
        .ls_ready  (ls_ready),
        .ls_res    (ls_res),
        .mem_valid (mem_valid),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_res   (mem_res)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ctl_byte(logic [AW-1:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(logic [AW-1:0] a);
        return {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
    endfunction

    function automatic logic [31:0] ctl_word(logic [AW-1:0] a);
        return {ctl_byte(a + 32'd3), ctl_byte(a + 32'd2), ctl_byte(a + 32'd1), ctl_byte(a)};
    endfunction

    // Little-endian load of 1/2/4 bytes with optional sign extension
    function automatic logic [31:0] load_val(logic [31:0] w, logic [2:0] len);
        int bits;
        logic [31:0] m;
        logic [31:0] v;
        bits = 8 << len[1:0];
        m = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        v = w & m;
        if (len[LEN_SIGNED_BIT] && bits < 32 && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    // Controller model: serves one request at a time, rdy_in gates its progress
    initial begin : ctrl
        bit busy;
        int cnt;
        logic          cw;
        logic [AW-1:0] ca;
        logic [2:0]    cl;
        logic [DW-1:0] cd;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk_in);
            #1;
            mem_ready = 1'b0;
            mem_res = '0;
            if (!rst_n_in) begin
                busy = 1'b0;
                rdy_in = 1'b1;
                continue;
            end
            rdy_in = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 9) != 0) : 1'b1);
            if (!rdy_in) continue;
            if (busy) begin
                check("mem_hold_valid", 32'(mem_valid), 32'd1);
                check("mem_hold_addr", mem_addr, ca);
                check("mem_hold_ctl", {28'd0, mem_wr, mem_len}, {28'd0, cw, cl});
            end
            if (!busy && mem_valid) begin
                busy = 1'b1;
                cw = mem_wr;
                ca = mem_addr;
                cl = mem_len;
                cd = mem_data;
                cnt = (ctrl_lat >= 0) ? ctrl_lat : int'($urandom_range(0, 3));
            end
            if (busy) begin
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    if (cw) begin
                        for (int i = 0; i < (1 << cl[1:0]); i++) ctl_mem[ca + AW'(i)] = cd[8*i +: 8];
                        mem_res = '0;
                    end else begin
                        mem_res = load_val(ctl_word(ca), cl);
                    end
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (if_ready) begin
                if (if_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_ready_unexpected got=1 exp=0 t=%0t", $time);
                end else begin
                    check("if_data", if_data, if_q.pop_front());
                end
            end else begin
                check("if_data_idle", if_data, 32'd0);
            end
            if (ls_ready) begin
                if (ls_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ls_ready_unexpected got=1 exp=0 t=%0t", $time);
                end else begin
                    check("ls_res", ls_res, ls_q.pop_front());
                end
            end else begin
                check("ls_res_idle", ls_res, 32'd0);
            end
        end
    end

    // Drivers are entered 2ns after a rising edge
    task automatic if_req(logic [AW-1:0] a, int flush_after);
        bit done;
        done = 1'b0;
        if_q.push_back(ref_word(a));
        if_valid = 1'b1;
        if_addr = a;
        for (int c = 0; c < BUDGET && !done; c++) begin
            @(negedge clk_in);
            if (if_ready) done = 1'b1;
            @(posedge clk_in);
            #2;
            if (!done && flush_after > 0 && c + 1 >= flush_after && rdy_in) begin
                flush_in = 1'b1;
                if_valid = 1'b0;
                void'(if_q.pop_back());
                @(posedge clk_in);
                #2;
                flush_in = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL if_timeout got=0 exp=1 addr=%h", a);
            if (if_q.size() > 0) void'(if_q.pop_back());
        end
        if_valid = 1'b0;
    endtask

    task automatic ls_req(bit wr, logic [AW-1:0] a, logic [2:0] len, logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        if (wr) begin
            for (int i = 0; i < (1 << len[1:0]); i++) ref_mem[a + AW'(i)] = d[8*i +: 8];
            ls_q.push_back('0);
        end else begin
            ls_q.push_back(load_val(ref_word(a), len));
        end
        ls_valid = 1'b1;
        ls_wr = wr;
        ls_addr = a;
        ls_len = len;
        ls_data = d;
        for (int c = 0; c < BUDGET && !done; c++) begin
            @(negedge clk_in);
            if (ls_ready) done = 1'b1;
            @(posedge clk_in);
            #2;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ls_timeout got=0 exp=1 addr=%h", a);
            if (ls_q.size() > 0) void'(ls_q.pop_back());
        end
        ls_valid = 1'b0;
    endtask

    task automatic wait_sig_negedge(string name, ref logic s);
        int c;
        c = 0;
        do begin
            @(negedge clk_in);
            c++;
        end while (!s && c < 50);
        if (!s) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=0 exp=1", name);
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_len", 32'(mem_len), 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_readys", {30'd0, if_ready, ls_ready}, 32'd0);
        check("rst_datas", if_data | ls_res, 32'd0);
        @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        @(posedge clk_in);
        #2;

        // Simultaneous requests: LS first, IF in the LS ready cycle
        fork
            if_req(32'h80, 0);
            ls_req(1'b0, 32'h100, LEN_W, '0);
            begin
                @(negedge clk_in);
                check("pair_pre_valid", 32'(mem_valid), 32'd0);
                @(negedge clk_in);
                check("pair_first_valid", 32'(mem_valid), 32'd1);
                check("pair_first_ls", mem_addr, 32'h100);
                wait_sig_negedge("pair_ls_ready", ls_ready);
                check("pair_if_lo", 32'(if_ready), 32'd0);
                @(negedge clk_in);
                check("pair_bubble_valid", 32'(mem_valid), 32'd1);
                check("pair_bubble_addr", mem_addr, 32'h80);
                check("pair_bubble_wr", 32'(mem_wr), 32'd0);
            end
        join

        fork
            ls_req(1'b1, 32'h100, LEN_W, 32'hDEAD_BEEF);
            begin
                @(negedge clk_in);
                check("wr_pre_valid", 32'(mem_valid), 32'd0);
                @(negedge clk_in);
                check("wr_valid", 32'(mem_valid), 32'd1);
                check("wr_addr", mem_addr, 32'h100);
                check("wr_wr", 32'(mem_wr), 32'd1);
                check("wr_len", 32'(mem_len), 32'(LEN_W));
                check("wr_data", mem_data, 32'hDEAD_BEEF);
                wait_sig_negedge("wr_ls_ready", ls_ready);
                check("wr_if_lo", 32'(if_ready), 32'd0);
            end
        join
        ls_req(1'b0, 32'h100, LEN_W, '0);
        ls_req(1'b1, 32'h104, LEN_B, 32'h80);
        ls_req(1'b0, 32'h104, 3'b100, '0);
        ls_req(1'b0, 32'h102, LEN_H, '0);
        ls_req(1'b0, 32'h102, 3'b101, '0);

        // Flush of an in-flight fetch, LS granted in the drain ready cycle
        ctrl_lat = 4;
        fork
            if_req(32'h0, 2);
            begin
                repeat (3) begin
                    @(posedge clk_in);
                    #2;
                end
                ls_req(1'b0, 32'h100, LEN_W, '0);
            end
            begin
                wait_sig_negedge("flush_mem_ready", mem_ready);
                check("flush_if_lo", 32'(if_ready), 32'd0);
                check("flush_drain_valid", 32'(mem_valid), 32'd1);
                check("flush_drain_addr", mem_addr, 32'h0);
                @(negedge clk_in);
                check("flush_ls_valid", 32'(mem_valid), 32'd1);
                check("flush_ls_addr", mem_addr, 32'h100);
            end
        join

        // rdy_in low for three cycles while LS is in flight
        ctrl_lat = 6;
        fork
            ls_req(1'b0, 32'h108, LEN_W, '0);
            begin
                @(negedge clk_in);
                @(negedge clk_in);
                rdy_hold = 1'b1;
                repeat (3) begin
                    @(negedge clk_in);
                    check("hold_valid", 32'(mem_valid), 32'd1);
                    check("hold_addr", mem_addr, 32'h108);
                    check("hold_len", 32'(mem_len), 32'(LEN_W));
                    check("hold_ls_lo", 32'(ls_ready), 32'd0);
                end
                rdy_hold = 1'b0;
            end
        join

        // Asynchronous reset in the middle of a fetch
        ctrl_lat = 5;
        if_valid = 1'b1;
        if_addr = 32'h40;
        repeat (2) @(posedge clk_in);
        #1;
        check("pre_rst_addr", mem_addr, 32'h40);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_len", 32'(mem_len), 32'd0);
        check("arst_if_ready", 32'(if_ready), 32'd0);
        if_valid = 1'b0;
        if_addr = '0;
        repeat (2) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        repeat (6) begin
            @(negedge clk_in);
            check("post_rst_valid", 32'(mem_valid), 32'd0);
        end

        // Randomized traffic with flushes and rdy_in stalls
        ctrl_lat = -1;
        rdy_rand = 1'b1;
        @(posedge clk_in);
        #2;
        fork
            begin
                repeat (50) begin
                    int gap;
                    int fa;
                    logic [AW-1:0] a;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk_in);
                        #2;
                    end
                    a = AW'($urandom_range(0, 63)) << 2;
                    fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
                    if_req(a, fa);
                end
            end
            begin
                repeat (70) begin
                    int gap;
                    int sz;
                    bit wr;
                    logic [AW-1:0] a;
                    logic [2:0] len;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk_in);
                        #2;
                    end
                    wr = 1'($urandom_range(0, 1));
                    sz = $urandom_range(0, 2);
                    a = 32'h100 + (AW'($urandom_range(0, 31)) & ~((AW'(1) << sz) - AW'(1)));
                    len = {wr ? 1'b0 : 1'($urandom_range(0, 1)), 2'(sz)};
                    ls_req(wr, a, len, $urandom);
                end
            end
        join
        rdy_rand = 1'b0;
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("ls_q_drained", 32'(ls_q.size()), 32'd0);
        check("end_mem_valid", 32'(mem_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-serial memory controller between the instruction-fetch path (IF, read-only word fetches) and the load/store path (LS, byte/half/word reads and writes). Sits between the icache/LSB and the memory controller. Latches one request at a time, drives it downstream until the controller's one-cycle `ready` pulse, and routes the response back to the owner. IF transactions can be cancelled by a flush without aborting the downstream access.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk_in` in 1: clock; single clock domain
- `rst_n_in` in 1: asynchronous, active-low reset
- `rdy_in` in 1: global enable; when low, all state is frozen
- `flush_in` in 1: cancel any pending or in-flight IF request
- `if_valid` in 1: IF request
- `if_addr` in ADDR_W: IF address; length is always word (3'b010)
- `if_ready` out 1: one-cycle completion pulse to IF
- `if_data` out DATA_W: fetched word; valid only while `if_ready`=1
- `ls_valid` in 1: LS request
- `ls_wr` in 1: 1 = write
- `ls_addr` in ADDR_W: LS address
- `ls_len` in 3: length code; bit 2 = sign-extend, [1:0] = 00 byte, 01 half, 10 word
- `ls_data` in DATA_W: store data
- `ls_ready` out 1: one-cycle completion pulse to LS
- `ls_res` out DATA_W: load result; valid only while `ls_ready`=1
- `mem_valid` out 1: request to the memory controller
- `mem_wr`, `mem_addr`, `mem_len`, `mem_data` out 1/ADDR_W/3/DATA_W: latched request fields
- `mem_ready` in 1: controller one-cycle done pulse
- `mem_res` in DATA_W: controller result; valid only while `mem_ready`=1

## Operation
- States: IDLE, BUSY_IF, BUSY_LS, DRAIN.
- IDLE: evaluate the eligible requesters (`if_valid && !flush_in`, `ls_valid`). On a grant, latch the request into `mem_*`, set `mem_valid`=1, and move to BUSY_IF or BUSY_LS.
- BUSY_x: hold `mem_*` stable. When `mem_ready`=1, drive `x_ready`=1 combinationally in the same cycle and pass `mem_res` through to `if_data` or `ls_res`.
  - At that edge, deassert `mem_valid` unless a new grant is made.
  - The completing requester is masked from arbitration in its own ready cycle, because its `valid` is still high.
  - The other requester may be granted in that same cycle, giving back-to-back service with no bubble.
- Flush:
  - In BUSY_IF, `flush_in` moves the state to DRAIN.
  - DRAIN keeps `mem_valid` and fields held until `mem_ready`. During that cycle, `if_ready` stays 0 and `if_data` is ignored. The state then returns to IDLE, or grants LS if `ls_valid`.
  - `flush_in` in BUSY_LS or DRAIN has no effect.
  - `flush_in` together with an `if_ready` cycle suppresses `if_ready`.
- Requester contract: hold `valid` and fields until the ready pulse. The next request may be presented in the cycle after the pulse.
- `if_data`/`ls_res` are 0 when the matching ready is low.
- `rdy_in`=0: no state, latch, or grant changes. `x_ready` is still forwarded combinationally from `mem_ready`.

## Timing
- Reset (async, `rst_n_in`=0):
  - State IDLE.
  - `mem_valid`=0; `mem_wr`=0; `mem_addr`=0; `mem_len`=0; `mem_data`=0.
  - `if_ready`=`ls_ready`=0; `if_data`=`ls_res`=0.
  - Priority pointer points to LS.
- Grant latency: request sampled at edge N; `mem_valid`=1 from cycle N+1.
- Completion: requester ready is asserted in the same cycle as `mem_ready`. Total latency is 1 + controller latency.
- `mem_valid` is registered. It is low for at least the cycle after each `mem_ready` unless a different requester is granted in that ready cycle.
- Reset mid-transaction drops everything immediately. The controller is reset by the same reset.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: when both requesters are eligible, the one not granted last wins. A 1-bit last-grant register updates on every grant.
  - Undefined: fixed priority, LS wins over IF. No last-grant register.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_t` (IDLE, BUSY_IF, BUSY_LS, DRAIN).
  - Length constants `LEN_B`=3'b000, `LEN_H`=3'b001, `LEN_W`=3'b010, `LEN_SIGNED_BIT`=2.
  - Owner encoding `OWN_IF`/`OWN_LS`.
- Sub-module `mem_arb_pick`: combinational winner selection. Inputs are eligible vector, mask, and last-grant; outputs are a one-hot grant. The policy macro is handled only inside this sub-module.

## Test plan
- LS word write, addr 0x100, data 0xDEADBEEF, IF idle -> `mem_valid` high from the cycle after request with fields latched; `ls_ready` pulses with `mem_ready`; `if_ready` stays 0.
- IF and LS assert in the same cycle -> LS granted first. Without the macro, IF is granted in the LS ready cycle with zero bubble. With `MEM_ARB_ROUND_ROBIN_EN`, a second simultaneous pair grants IF first.
- IF fetch from 0x0 in flight, `flush_in` pulsed mid-access -> `mem_valid` held until `mem_ready`; `if_ready` never pulses; a following LS request is granted in the drain ready cycle.
- LS signed byte read (len 3'b100) returning 0xFFFFFF80 -> `ls_res`=0xFFFFFF80 only during the `ls_ready` cycle, 0 otherwise.
- `rdy_in` held low 3 cycles during BUSY_LS -> `mem_*` and state unchanged; completion resumes when `rdy_in` returns.
- `rst_n_in` asserted asynchronously mid BUSY_IF -> all outputs 0 immediately, state IDLE, no ready pulse after release.
